// File: rtl/vga_scan_gen.sv
// 640x480@60 raster timing generator. Presents scan coordinates to the glyph
// renderer and re-aligns its 1-bit result with sync/blanking after PIPE+1 ticks.
module vga_scan_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int PIPE     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix,
    input  logic [7:0] fg_color,
    input  logic [7:0] bg_color,
    output logic [9:0] horizontal,
    output logic [8:0] vertical,
    output logic       pix_tick,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] rgb,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Delay-line word layout: {active, hs, vs}; idle value is blanked with syncs released.
    localparam logic [2:0] DLY_IDLE = 3'b011;

    logic [3:0] div;
    logic       tick;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       h_wrap;
    logic       v_wrap;
    logic [2:0] raw_bus;
    logic [2:0] dly_bus;

    // With CLK_DIV=1 DIV_LAST is 0, div never leaves 0 and tick is constantly high.
    assign tick     = (div == DIV_LAST);
    assign pix_tick = tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 4'd1;
        end
    end

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        v_wrap = (v_cnt == V_LAST);
        h_next = h_wrap ? 10'd0 : h_cnt + 10'd1;
        v_next = v_cnt;
        if (h_wrap) begin
            v_next = v_wrap ? 10'd0 : v_cnt + 10'd1;
        end
    end

    // Coordinates are registered from the next counter values so they always
    // match the raster position held in h_cnt/v_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            horizontal <= '0;
            vertical   <= '0;
        end else if (tick) begin
            h_cnt      <= h_next;
            v_cnt      <= v_next;
            horizontal <= (h_next < H_ACT) ? h_next : 10'd0;
            vertical   <= (v_next < V_ACT) ? v_next[8:0] : 9'd0;
        end
    end

    always_comb begin
        raw_bus[2] = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        raw_bus[1] = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        raw_bus[0] = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    end

    generate
        if (PIPE == 0) begin : g_no_pipe
            assign dly_bus = raw_bus;
        end else begin : g_pipe
            logic [2:0] stage [PIPE];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE; i++) begin
                        stage[i] <= DLY_IDLE;
                    end
                end else if (tick) begin
                    stage[0] <= raw_bus;
                    for (int i = 1; i < PIPE; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dly_bus = stage[PIPE-1];
        end
    endgenerate

    // Output stage adds the final tick of lag, so colour and syncs leave together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= 8'h00;
        end else if (tick) begin
            hsync <= dly_bus[1];
            vsync <= dly_bus[0];
            rgb   <= dly_bus[2] ? (pix ? fg_color : bg_color) : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick && h_wrap && v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: four instances (small rasters plus the full 640x480)
// checked against an arithmetic raster model, a vector table and timing sequences.
module tb_vga_scan_gen;

    localparam int NI = 4;
    localparam int P_HA[NI] = '{16, 16, 10, 640};
    localparam int P_HF[NI] = '{4, 4, 2, 16};
    localparam int P_HS[NI] = '{6, 6, 3, 96};
    localparam int P_HB[NI] = '{6, 6, 5, 48};
    localparam int P_VA[NI] = '{6, 6, 4, 480};
    localparam int P_VF[NI] = '{2, 2, 1, 10};
    localparam int P_VS[NI] = '{2, 2, 1, 2};
    localparam int P_VB[NI] = '{3, 3, 2, 33};
    localparam int P_DV[NI] = '{2, 1, 3, 2};
    localparam int P_PP[NI] = '{2, 0, 5, 2};

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, dv, pp;
    } cfg_t;

    typedef struct {
        int n;
        int hor;
        int ver;
        int hs;
        int vs;
        int tk;
        int fs;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [NI-1:0]      pix_i;
    logic [NI-1:0][7:0] fg_i;
    logic [NI-1:0][7:0] bg_i;
    logic [NI-1:0][9:0] hor_o;
    logic [NI-1:0][8:0] ver_o;
    logic [NI-1:0]      tk_o;
    logic [NI-1:0]      hs_o;
    logic [NI-1:0]      vs_o;
    logic [NI-1:0][7:0] rgb_o;
    logic [NI-1:0]      fs_o;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            vga_scan_gen #(
                .H_ACTIVE(P_HA[g]), .H_FP(P_HF[g]), .H_SYNC(P_HS[g]), .H_BP(P_HB[g]),
                .V_ACTIVE(P_VA[g]), .V_FP(P_VF[g]), .V_SYNC(P_VS[g]), .V_BP(P_VB[g]),
                .CLK_DIV(P_DV[g]), .PIPE(P_PP[g])
            ) u_dut (
                .clk         (clk),
                .rst_n       (rst_n),
                .pix         (pix_i[g]),
                .fg_color    (fg_i[g]),
                .bg_color    (bg_i[g]),
                .horizontal  (hor_o[g]),
                .vertical    (ver_o[g]),
                .pix_tick    (tk_o[g]),
                .hsync       (hs_o[g]),
                .vsync       (vs_o[g]),
                .rgb         (rgb_o[g]),
                .frame_start (fs_o[g])
            );
        end
    endgenerate

    int   checks;
    int   errors;
    int   n;
    bit   color_mode;
    logic [7:0] rgb_model [NI];
    logic [7:0] rgb_pend  [NI];

    int   hs_fall [NI];
    int   hs_fall_prev [NI];
    int   hs_low [NI];
    int   hs_dly [NI];
    int   h_wrap_n [NI];
    int   vs_fall [NI];
    int   vs_low [NI];
    int   fs_last [NI];
    int   fs_prev [NI];
    logic prev_hs [NI];
    logic prev_vs [NI];
    logic [9:0] prev_hor [NI];

    function automatic cfg_t mk_cfg(input int g);
        cfg_t c;
        c.ha = P_HA[g]; c.hf = P_HF[g]; c.hs = P_HS[g]; c.hb = P_HB[g];
        c.va = P_VA[g]; c.vf = P_VF[g]; c.vs = P_VS[g]; c.vb = P_VB[g];
        c.dv = P_DV[g]; c.pp = P_PP[g];
        return c;
    endfunction

    function automatic int htot(input cfg_t c);
        return c.ha + c.hf + c.hs + c.hb;
    endfunction

    function automatic int vtot(input cfg_t c);
        return c.va + c.vf + c.vs + c.vb;
    endfunction

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d n=%0d: got %0h, expected %0h", name, g, n, act, exp);
        end
    endtask

    // Raster model: after n clk edges since release, t = n / CLK_DIV ticks have
    // elapsed; the presented coordinate is t mod line/frame, outputs show t - L.
    task automatic check_all();
        for (int g = 0; g < NI; g++) begin
            cfg_t c;
            int t, x, y, ct, cx, cy, ht, vt, lag, e_h, e_v, e_tk, e_fs, e_hs, e_vs;
            c = mk_cfg(g);
            if (!rst_n) begin
                rgb_model[g] = 8'h00;
                chk("rst_horizontal", g, 32'(hor_o[g]), 0);
                chk("rst_vertical", g, 32'(ver_o[g]), 0);
                chk("rst_hsync", g, 32'(hs_o[g]), 1);
                chk("rst_vsync", g, 32'(vs_o[g]), 1);
                chk("rst_rgb", g, 32'(rgb_o[g]), 0);
                chk("rst_frame_start", g, 32'(fs_o[g]), 0);
                chk("rst_pix_tick", g, 32'(tk_o[g]), (c.dv == 1) ? 1 : 0);
            end else begin
                ht  = htot(c);
                vt  = vtot(c);
                lag = c.pp + 1;
                t   = n / c.dv;
                if (n > 0 && n % c.dv == 0) rgb_model[g] = rgb_pend[g];
                x    = t % ht;
                y    = (t / ht) % vt;
                e_h  = (x < c.ha) ? x : 0;
                e_v  = (y < c.va) ? y : 0;
                e_tk = ((n % c.dv) == (c.dv - 1)) ? 1 : 0;
                e_fs = (n > 0 && n % c.dv == 0 && t % (ht * vt) == 0) ? 1 : 0;
                e_hs = 1;
                e_vs = 1;
                if (t >= lag) begin
                    ct = t - lag;
                    cx = ct % ht;
                    cy = (ct / ht) % vt;
                    e_hs = (cx >= c.ha + c.hf && cx < c.ha + c.hf + c.hs) ? 0 : 1;
                    e_vs = (cy >= c.va + c.vf && cy < c.va + c.vf + c.vs) ? 0 : 1;
                end
                chk("horizontal", g, 32'(hor_o[g]), e_h);
                chk("vertical", g, 32'(ver_o[g]), e_v);
                chk("pix_tick", g, 32'(tk_o[g]), e_tk);
                chk("frame_start", g, 32'(fs_o[g]), e_fs);
                chk("hsync", g, 32'(hs_o[g]), e_hs);
                chk("vsync", g, 32'(vs_o[g]), e_vs);
                chk("rgb", g, 32'(rgb_o[g]), 32'(rgb_model[g]));
            end
        end
    endtask

    // Acts as the renderer: before a tick edge, present the result for the
    // coordinate that edge's output describes; off-tick cycles carry junk.
    task automatic drive_all();
        for (int g = 0; g < NI; g++) begin
            cfg_t c;
            int nn, tn, ct, cx, cy, ht, vt;
            logic p, act;
            logic [7:0] f, b;
            c  = mk_cfg(g);
            nn = n + 1;
            if (rst_n && nn % c.dv == 0) begin
                ht  = htot(c);
                vt  = vtot(c);
                tn  = nn / c.dv;
                act = 1'b0;
                p   = 1'($urandom_range(0, 1));
                if (tn >= c.pp + 1) begin
                    ct  = tn - (c.pp + 1);
                    cx  = ct % ht;
                    cy  = (ct / ht) % vt;
                    act = (cx < c.ha) && (cy < c.va);
                    if (color_mode) p = (cx == 5) && (cy == 0);
                end
                f = color_mode ? 8'hE0 : 8'($urandom);
                b = color_mode ? 8'h03 : 8'($urandom);
                pix_i[g]    = p;
                fg_i[g]     = f;
                bg_i[g]     = b;
                rgb_pend[g] = act ? (p ? f : b) : 8'h00;
            end else begin
                pix_i[g] = 1'($urandom);
                fg_i[g]  = 8'($urandom);
                bg_i[g]  = 8'($urandom);
            end
        end
    endtask

    task automatic reset_meas();
        for (int g = 0; g < NI; g++) begin
            hs_fall[g] = -1; hs_fall_prev[g] = -1; hs_low[g] = -1; hs_dly[g] = -1;
            h_wrap_n[g] = -1; vs_fall[g] = -1; vs_low[g] = -1;
            fs_last[g] = -1; fs_prev[g] = -1;
            prev_hs[g] = 1'b1; prev_vs[g] = 1'b1; prev_hor[g] = '0;
        end
    endtask

    task automatic track_edges();
        for (int g = 0; g < NI; g++) begin
            if (prev_hor[g] == 10'(P_HA[g] - 1) && hor_o[g] == 10'd0) h_wrap_n[g] = n;
            if (prev_hs[g] && !hs_o[g]) begin
                hs_fall_prev[g] = hs_fall[g];
                hs_fall[g] = n;
                hs_dly[g] = n - h_wrap_n[g];
            end
            if (!prev_hs[g] && hs_o[g]) hs_low[g] = n - hs_fall[g];
            if (prev_vs[g] && !vs_o[g]) vs_fall[g] = n;
            if (!prev_vs[g] && vs_o[g]) vs_low[g] = n - vs_fall[g];
            if (fs_o[g]) begin
                fs_prev[g] = fs_last[g];
                fs_last[g] = n;
            end
            prev_hs[g]  = hs_o[g];
            prev_vs[g]  = vs_o[g];
            prev_hor[g] = hor_o[g];
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) n++;
        @(negedge clk);
        check_all();
        track_edges();
        drive_all();
    endtask

    task automatic release_rst();
        rst_n = 1'b1;
        n = 0;
        reset_meas();
        drive_all();
    endtask

    vec_t tbl[18];
    int   cnt_fg, cnt_bg, cnt_blank;

    initial begin
        // Instance 0: 32x13 raster, CLK_DIV=2, PIPE=2 (lag 3 ticks = 6 clk).
        tbl = '{
            '{0,   0,  0, 1, 1, 0, 0},
            '{1,   0,  0, 1, 1, 1, 0},
            '{2,   1,  0, 1, 1, 0, 0},
            '{31,  15, 0, 1, 1, 1, 0},
            '{33,  0,  0, 1, 1, 1, 0},
            '{45,  0,  0, 1, 1, 1, 0},
            '{46,  0,  0, 0, 1, 0, 0},
            '{57,  0,  0, 0, 1, 1, 0},
            '{58,  0,  0, 1, 1, 0, 0},
            '{66,  1,  1, 1, 1, 0, 0},
            '{384, 0,  0, 1, 1, 0, 0},
            '{517, 2,  0, 1, 1, 1, 0},
            '{518, 3,  0, 1, 0, 0, 0},
            '{645, 2,  0, 1, 0, 1, 0},
            '{646, 3,  0, 1, 1, 0, 0},
            '{831, 0,  0, 1, 1, 1, 0},
            '{832, 0,  0, 1, 1, 0, 1},
            '{833, 0,  0, 1, 1, 1, 0}
        };
        checks = 0;
        errors = 0;
        n = 0;
        color_mode = 1'b0;
        rst_n = 1'b0;
        pix_i = '0;
        fg_i = '0;
        bg_i = '0;
        for (int g = 0; g < NI; g++) begin
            rgb_model[g] = 8'h00;
            rgb_pend[g]  = 8'h00;
        end
        reset_meas();
        repeat (3) step();
        release_rst();

        for (int i = 0; i < 18; i++) begin
            while (n < tbl[i].n) step();
            chk("tbl_horizontal", 0, 32'(hor_o[0]), tbl[i].hor);
            chk("tbl_vertical", 0, 32'(ver_o[0]), tbl[i].ver);
            chk("tbl_hsync", 0, 32'(hs_o[0]), tbl[i].hs);
            chk("tbl_vsync", 0, 32'(vs_o[0]), tbl[i].vs);
            chk("tbl_pix_tick", 0, 32'(tk_o[0]), tbl[i].tk);
            chk("tbl_frame_start", 0, 32'(fs_o[0]), tbl[i].fs);
        end

        // Colour path: pix=1 only for (5,0); count one frame of output ticks.
        color_mode = 1'b1;
        step();
        for (int s = 0; s < 2000 && !fs_o[0]; s++) step();
        chk("colour_frame_start_seen", 0, 32'(fs_o[0]), 1);
        cnt_fg = 0;
        cnt_bg = 0;
        cnt_blank = 0;
        for (int s = 0; s < 832; s++) begin
            step();
            if (tk_o[0]) begin
                if (rgb_o[0] == 8'hE0) cnt_fg++;
                else if (rgb_o[0] == 8'h03) cnt_bg++;
                else if (rgb_o[0] == 8'h00) cnt_blank++;
            end
        end
        chk("colour_fg_ticks", 0, cnt_fg, 1);
        chk("colour_bg_ticks", 0, cnt_bg, 95);
        chk("colour_blank_ticks", 0, cnt_blank, 320);
        color_mode = 1'b0;

        // Asynchronous reset in the middle of a frame.
        for (int s = 0; s < 900 && (n % 832) != 300; s++) step();
        rst_n = 1'b0;
        n = 0;
        #1;
        check_all();
        repeat (3) step();
        release_rst();
        step();
        chk("rel_horizontal_1clk", 0, 32'(hor_o[0]), 0);
        step();
        chk("rel_horizontal_2clk", 0, 32'(hor_o[0]), 1);

        repeat (3400) step();
        for (int g = 0; g < NI; g++) begin
            cfg_t c;
            c = mk_cfg(g);
            chk("hsync_period", g, hs_fall[g] - hs_fall_prev[g], htot(c) * c.dv);
            chk("hsync_low", g, hs_low[g], c.hs * c.dv);
            chk("hsync_lag", g, hs_dly[g], (c.hf + c.pp + 1) * c.dv);
        end
        for (int g = 0; g < 3; g++) begin
            cfg_t c;
            c = mk_cfg(g);
            chk("frame_period", g, fs_last[g] - fs_prev[g], htot(c) * vtot(c) * c.dv);
            chk("vsync_low", g, vs_low[g], c.vs * htot(c) * c.dv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
